mem_stream_dma: RTL and testbench

MEM_STREAM_DMA -- requirements
Module: mem_stream_dma

---
 rtl/mem_stream_dma.sv | 174 +++++++++++++++++
 tb/tb_mem_stream_dma.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_dma.sv
// mem_stream_dma
// Moves a block of words between a word-addressed memory and two streams.
// The read side fetches len words starting at rd_base and presents them on a
// valid/ready output stream; the write side accepts len words from a
// valid/ready input stream and writes them starting at wr_base. Both sides
// run independently; the transfer completes once both have drained, and a
// one-cycle done/mem_done pulse follows.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start               transfer request, honoured only when idle
//   rd_base, wr_base    source / destination base addresses
//   len                 number of words to move (0 = empty transfer)
//   mem_addr, mem_read  combinational read request; mem_rdata returns same cycle
//   mem_rdata           read data
//   mem_we, mem_waddr,
//   mem_wdata           registered write port
//   mem_done            completion pulse to the memory
//   out_valid/ready/data  read stream
//   in_valid/ready/data   write stream
//   busy, done          not-idle status, completion pulse
module mem_stream_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    input  logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

    logic [1:0]        state_r;
    logic [ADDR_W-1:0] rd_base_r;
    logic [ADDR_W-1:0] wr_base_r;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] rd_cnt_r;
    logic [ADDR_W-1:0] wr_cnt_r;
    logic [ADDR_W-1:0] addr_hold_r;

    logic [ADDR_W-1:0] rd_addr_s;
    logic              read_en_s;
    logic              in_ready_s;
    logic              wr_fire_s;
    logic              rd_fin_s;
    logic              wr_fin_s;

    // Read/write enables and completion terms for the current cycle.
    always_comb begin
        rd_addr_s  = rd_base_r + rd_cnt_r;
        read_en_s  = 1'b0;
        in_ready_s = 1'b0;
        if (!rst && (state_r == S_RUN)) begin
            // A new word may be fetched only if the output slot is empty or
            // is being emptied this cycle.
            read_en_s  = (rd_cnt_r < len_r) && (!out_valid || out_ready);
            in_ready_s = (wr_cnt_r < len_r);
        end else begin
            read_en_s  = 1'b0;
            in_ready_s = 1'b0;
        end
        wr_fire_s = in_valid && in_ready_s;
        // Read side is finished once every word is fetched and the last one
        // leaves the output slot no later than this cycle.
        rd_fin_s  = (rd_cnt_r == len_r) && (!out_valid || out_ready);
        // Write side is finished once every word is accepted; the final
        // mem_we is in this cycle at the latest.
        wr_fin_s  = (wr_cnt_r == len_r);
    end

    assign mem_read = read_en_s;
    assign in_ready = in_ready_s;
    assign mem_addr = rst ? ZERO_A : (read_en_s ? rd_addr_s : addr_hold_r);
    assign busy     = !rst && (state_r != S_IDLE);
    assign done     = !rst && (state_r == S_DONE);
    assign mem_done = !rst && (state_r == S_DONE);

    // Control FSM, latched transfer parameters and progress counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= S_IDLE;
            rd_base_r <= ZERO_A;
            wr_base_r <= ZERO_A;
            len_r     <= ZERO_A;
            rd_cnt_r  <= ZERO_A;
            wr_cnt_r  <= ZERO_A;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        rd_base_r <= rd_base;
                        wr_base_r <= wr_base;
                        len_r     <= len;
                        rd_cnt_r  <= ZERO_A;
                        wr_cnt_r  <= ZERO_A;
                        state_r   <= (len == ZERO_A) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (read_en_s) begin
                        rd_cnt_r <= rd_cnt_r + ONE_A;
                    end
                    if (wr_fire_s) begin
                        wr_cnt_r <= wr_cnt_r + ONE_A;
                    end
                    if (rd_fin_s && wr_fin_s) begin
                        state_r <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output-stream slot: load on a fetch, drain on a handshake without reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= ZERO_D;
            addr_hold_r <= ZERO_A;
        end else if (read_en_s) begin
            out_valid   <= 1'b1;
            out_data    <= mem_rdata;
            addr_hold_r <= rd_addr_s;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Registered memory write port, one cycle after each input handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_waddr <= ZERO_A;
            mem_wdata <= ZERO_D;
        end else begin
            mem_we <= wr_fire_s;
            if (wr_fire_s) begin
                mem_waddr <= wr_base_r + wr_cnt_r;
                mem_wdata <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_dma.sv
// Self-checking bench for mem_stream_dma: transaction-level model checked
// every cycle, plus directed timelines with literal expectations.
module tb_mem_stream_dma;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rd_base, wr_base, len;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        busy, done;

    always #5 clk = ~clk;

    logic [31:0] src [256];
    assign mem_rdata = mem_read ? src[mem_addr] : 32'hDEAD_BEEF;

    mem_stream_dma #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rd_base(rd_base), .wr_base(wr_base), .len(len),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_done(mem_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .busy(busy), .done(done)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (transaction counts) ----------------
    int          m_phase;      // 0 idle, 1 moving words, 2 completion cycle
    int          m_rb, m_wb, m_len;
    int          m_issued, m_delivered, m_accepted;
    bit          m_wpend;
    logic [7:0]  m_last_addr, m_waddr;
    logic [31:0] m_out_data, m_wdata;

    initial begin : compare
        bit         held, exp_read, exp_inr, out_hs, in_hs;
        logic [7:0] exp_addr;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_phase = 0; m_rb = 0; m_wb = 0; m_len = 0;
                m_issued = 0; m_delivered = 0; m_accepted = 0;
                m_wpend = 1'b0; m_last_addr = 8'h00; m_waddr = 8'h00;
                m_out_data = 32'h0; m_wdata = 32'h0;
            end else begin
                held     = (m_issued > m_delivered);
                exp_read = (m_phase == 1) && (m_issued < m_len) && (!held || out_ready);
                exp_addr = exp_read ? 8'(m_rb + m_issued) : m_last_addr;
                exp_inr  = (m_phase == 1) && (m_accepted < m_len);
                chk("busy",      64'(busy),      64'(m_phase != 0));
                chk("done",      64'(done),      64'(m_phase == 2));
                chk("mem_done",  64'(mem_done),  64'(m_phase == 2));
                chk("mem_read",  64'(mem_read),  64'(exp_read));
                chk("mem_addr",  64'(mem_addr),  64'(exp_addr));
                chk("out_valid", 64'(out_valid), 64'(held));
                chk("out_data",  64'(out_data),  64'(m_out_data));
                chk("in_ready",  64'(in_ready),  64'(exp_inr));
                chk("mem_we",    64'(mem_we),    64'(m_wpend));
                chk("mem_waddr", 64'(mem_waddr), 64'(m_waddr));
                chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));

                out_hs = held && out_ready;
                in_hs  = in_valid && exp_inr;
                case (m_phase)
                    0: if (start) begin
                        m_rb = int'(rd_base); m_wb = int'(wr_base); m_len = int'(len);
                        m_issued = 0; m_delivered = 0; m_accepted = 0;
                        m_phase = (len == 8'd0) ? 2 : 1;
                    end
                    1: if ((m_delivered + int'(out_hs)) == m_len && m_accepted == m_len)
                        m_phase = 2;
                    default: m_phase = 0;
                endcase
                if (exp_read) begin
                    m_out_data  = src[exp_addr];
                    m_last_addr = exp_addr;
                    m_issued++;
                end
                if (out_hs) m_delivered++;
                m_wpend = in_hs;
                if (in_hs) begin
                    m_waddr = 8'(m_wb + m_accepted);
                    m_wdata = in_data;
                    m_accepted++;
                end
            end
        end
    end

    // ---------------- per-transfer trace ----------------
    bit          tr_read [256];
    logic [7:0]  tr_addr [256];
    bit          tr_ov   [256];
    logic [31:0] tr_od   [256];
    bit          tr_we   [256];
    logic [7:0]  tr_waddr[256];
    bit          tr_done [256];
    bit          tr_mdone[256];
    bit          tr_busy [256];
    int          tr_n;
    int          done_k;
    logic [7:0]  ra[$];
    logic [31:0] dq[$];
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [31:0] oq[$];

    // mode 0: always ready/valid; 1: out_ready low cycles 2-4; 2: random;
    // 3: in_valid withheld until all reads delivered, extra start pulses.
    task automatic run_xfer(input logic [7:0] rb, input logic [7:0] wb,
                            input logic [7:0] ln, input int mode);
        int n_done, n_mdone;
        done_k = -1; tr_n = 0;
        ra.delete(); dq.delete(); wa.delete(); wd.delete(); oq.delete();
        for (int k = 0; k < 200; k++) begin
            start   = (k == 0) || (mode == 3 && (k == 2 || k == 3));
            rd_base = (k == 0) ? rb : 8'($urandom);
            wr_base = (k == 0) ? wb : 8'($urandom);
            len     = (k == 0) ? ln : 8'($urandom);
            out_ready = (mode == 1) ? !(k >= 2 && k <= 4)
                      : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (mode == 2) ? 1'($urandom_range(0, 1))
                      : (mode == 3) ? (dq.size() >= int'(ln)) : 1'b1;
            in_data   = $urandom;
            @(negedge clk);
            tr_read[k] = mem_read;  tr_addr[k] = mem_addr;
            tr_ov[k] = out_valid;   tr_od[k] = out_data;
            tr_we[k] = mem_we;      tr_waddr[k] = mem_waddr;
            tr_done[k] = done;      tr_mdone[k] = mem_done; tr_busy[k] = busy;
            tr_n = k + 1;
            if (mem_read) ra.push_back(mem_addr);
            if (out_valid && out_ready) dq.push_back(out_data);
            if (mem_we) begin wa.push_back(mem_waddr); wd.push_back(mem_wdata); end
            if (in_valid && in_ready) oq.push_back(in_data);
            if (done && done_k < 0) done_k = k;
            @(posedge clk); #1;
            if (done_k >= 0 && k >= done_k + 2) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("completion_seen", 64'(done_k >= 0), 64'(1));
        chk("n_reads", 64'(ra.size()), 64'(ln));
        for (int i = 0; i < ra.size() && i < int'(ln); i++)
            chk("rd_addr_seq", 64'(ra[i]), 64'(8'(rb + i)));
        chk("n_out_words", 64'(dq.size()), 64'(ln));
        for (int i = 0; i < dq.size() && i < int'(ln); i++)
            chk("out_word_seq", 64'(dq[i]), 64'(src[8'(rb + i)]));
        chk("n_writes", 64'(wa.size()), 64'(ln));
        for (int i = 0; i < wa.size() && i < int'(ln) && i < oq.size(); i++) begin
            chk("wr_addr_seq", 64'(wa[i]), 64'(8'(wb + i)));
            chk("wr_data_seq", 64'(wd[i]), 64'(oq[i]));
        end
        n_done = 0; n_mdone = 0;
        for (int k = 0; k < tr_n; k++) begin
            n_done  += int'(tr_done[k]);
            n_mdone += int'(tr_mdone[k]);
        end
        chk("done_pulses", 64'(n_done), 64'(1));
        chk("mem_done_pulses", 64'(n_mdone), 64'(1));
    endtask

    initial begin
        int last_we, nwe;
        for (int i = 0; i < 256; i++) src[i] = $urandom;
        rst = 1'b1; start = 1'b0; rd_base = 8'h00; wr_base = 8'h00; len = 8'h00;
        out_ready = 1'b1; in_valid = 1'b0; in_data = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy",     64'(busy),      64'(0));
        chk("reset_outvalid", 64'(out_valid), 64'(0));
        chk("reset_outdata",  64'(out_data),  64'(0));
        chk("reset_memaddr",  64'(mem_addr),  64'(0));
        chk("reset_inready",  64'(in_ready),  64'(0));
        @(posedge clk); #1;

        // Basic timeline, all handshakes immediate.
        run_xfer(8'h10, 8'h40, 8'd4, 0);
        for (int k = 0; k <= 8; k++) begin
            chk("t1_mem_read", 64'(tr_read[k]), 64'(k >= 1 && k <= 4));
            if (k >= 1 && k <= 4) chk("t1_mem_addr", 64'(tr_addr[k]), 64'(8'h10 + k - 1));
            chk("t1_out_valid", 64'(tr_ov[k]), 64'(k >= 2 && k <= 5));
            chk("t1_mem_we", 64'(tr_we[k]), 64'(k >= 2 && k <= 5));
            if (k >= 2 && k <= 5) chk("t1_mem_waddr", 64'(tr_waddr[k]), 64'(8'h40 + k - 2));
            chk("t1_done", 64'(tr_done[k]), 64'(k == 6));
            chk("t1_mem_done", 64'(tr_mdone[k]), 64'(k == 6));
            chk("t1_busy", 64'(tr_busy[k]), 64'(k >= 1 && k <= 6));
        end

        // Output stall for three cycles after the first load.
        run_xfer(8'h20, 8'h80, 8'd4, 1);
        chk("t2_first_word", 64'(tr_od[2]), 64'(src[8'h20]));
        for (int k = 3; k <= 4; k++) chk("t2_data_stable", 64'(tr_od[k]), 64'(src[8'h20]));
        for (int k = 2; k <= 4; k++) chk("t2_no_read_stall", 64'(tr_read[k]), 64'(0));

        // Empty transfer.
        run_xfer(8'h05, 8'h06, 8'd0, 0);
        chk("t3_done_cycle", 64'(done_k), 64'(1));
        chk("t3_idle_after", 64'(tr_busy[2]), 64'(0));

        // Source address wrap.
        run_xfer(8'hFE, 8'h30, 8'd3, 0);
        if (ra.size() == 3) begin
            chk("t4_addr0", 64'(ra[0]), 64'(8'hFE));
            chk("t4_addr1", 64'(ra[1]), 64'(8'hFF));
            chk("t4_addr2", 64'(ra[2]), 64'(8'h00));
        end else begin
            chk("t4_read_count", 64'(ra.size()), 64'(3));
        end

        // Writes only after reads drain, with start pulses while running.
        run_xfer(8'h70, 8'h90, 8'd4, 3);
        last_we = -1;
        for (int k = 0; k < tr_n; k++) if (tr_we[k]) last_we = k;
        chk("t5_done_after_last_we", 64'(done_k), 64'(last_we + 1));
        chk("t5_last_we_cycle", 64'(last_we), 64'(10));

        // Reset in the middle of a transfer after two writes.
        rd_base = 8'h50; wr_base = 8'hA0; len = 8'd8;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        nwe = 0;
        for (int c = 0; c < 20 && nwe < 2; c++) begin
            in_data = $urandom;
            @(negedge clk);
            if (mem_we) nwe++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        chk("t6_two_writes", 64'(nwe), 64'(2));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("t6_mem_read",  64'(mem_read),  64'(0));
        chk("t6_mem_addr",  64'(mem_addr),  64'(0));
        chk("t6_mem_we",    64'(mem_we),    64'(0));
        chk("t6_mem_waddr", 64'(mem_waddr), 64'(0));
        chk("t6_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("t6_mem_done",  64'(mem_done),  64'(0));
        chk("t6_out_valid", 64'(out_valid), 64'(0));
        chk("t6_out_data",  64'(out_data),  64'(0));
        chk("t6_in_ready",  64'(in_ready),  64'(0));
        chk("t6_busy",      64'(busy),      64'(0));
        chk("t6_done",      64'(done),      64'(0));
        @(posedge clk); #1;
        run_xfer(8'h60, 8'hC0, 8'd5, 0);
        if (wa.size() > 0) chk("t6_restart_waddr", 64'(wa[0]), 64'(8'hC0));

        // Randomized transfers with random handshakes.
        for (int t = 0; t < 8; t++)
            run_xfer(8'($urandom), 8'($urandom), 8'($urandom_range(1, 12)), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
